// File: rtl/serial_full_subtractor_if.sv
// Start/done handshake bundle for serial_full_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_full_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    // Requester side: issues operands, observes status and result
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    // Subtractor side
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop; WIDTH cycles busy per operation.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_full_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r, done_r;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a0, b0, d, br_nxt;
    logic             accept, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_r;
`endif

    // Full-subtractor cell on the current LSBs and handshake decode
    always_comb begin
        a0     = a_sr[0];
        b0     = b_sr[0];
        d      = a0 ^ b0 ^ br;
        br_nxt = (~a0 & b0) | (~a0 & br) | (b0 & br);
        accept = (state == IDLE) && bus.start;
        last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start is only looked at while idle, so requests during SHIFT are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Operand shifting, borrow chain and result capture; outputs only move at completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            done_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                a_sr <= bus.a;
                b_sr <= bus.b;
                br   <= bus.bin;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {d, res_sr[WIDTH-1:1]};
                br     <= br_nxt;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    diff_r <= {d, res_sr[WIDTH-1:1]};
                    bout_r <= br_nxt;
                    done_r <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // borrow into MSB differs from borrow out of MSB -> signed overflow
                    ovf_r  <= br ^ br_nxt;
`endif
                end
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_r;
`endif
endmodule

// File: tb/tb_serial_full_subtractor.sv
// Self-checking bench for serial_full_subtractor (WIDTH=8), directed scenarios plus random vectors
// against an arithmetic reference of a - b - bin. Build with or without SERIAL_SUB_OVF_EN.
module tb_serial_full_subtractor;
    localparam int WIDTH = 8;
    localparam int TMO   = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_full_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_full_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on widened operands
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, b, input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        ref_sub = {r < 0, WIDTH'(r)};
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] a, b, input logic bin);
        int r;
        r = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ref_ovf = (r < -(1 << (WIDTH - 1))) || (r > (1 << (WIDTH - 1)) - 1);
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
        get_ovf = bus.ovf;
`else
        get_ovf = 1'b0;
`endif
    endfunction

    // Issue one request and wait for done; lat = edges from accept to done visible
    task automatic do_op(input logic [WIDTH-1:0] a, b, input logic bin, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.diff, bus.bout, get_ovf()} !== '0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b diff=%h bout=%b ovf=%b, required all 0",
                     bus.busy, bus.done, bus.diff, bus.bout, get_ovf());
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
        logic [WIDTH-1:0] vb [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
        logic             vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [WIDTH-1:0] xd [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
        logic             xb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic             xo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], lat);
            n_cmp++;
            if (lat !== WIDTH) begin
                n_err++; $display("FAIL directed%0d latency: got %0d need %0d", i, lat, WIDTH);
            end
            n_cmp++;
            if ({bus.bout, bus.diff} !== {xb[i], xd[i]}) begin
                n_err++; $display("FAIL directed%0d result: got bout=%b diff=%h need bout=%b diff=%h",
                                  i, bus.bout, bus.diff, xb[i], xd[i]);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_cmp++;
            if (bus.ovf !== xo[i]) begin
                n_err++; $display("FAIL directed%0d ovf: got %b need %b", i, bus.ovf, xo[i]);
            end
`else
            if (xo[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_ignore_busy();
        int lat, dones;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h05; bus.b = 8'h03; bus.bin = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        lat = 0; dones = 0;
        while (!bus.done && lat < TMO) begin
            // cycles 2..5 of the operation: new requests that must be dropped
            if (lat >= 1 && lat <= 4) begin
                bus.start = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.bin = $urandom;
            end else bus.start = 1'b0;
            n_cmp++;
            if (bus.busy !== 1'b1) begin
                n_err++; $display("FAIL busy_during_op: got %b need 1 at cycle %0d", bus.busy, lat);
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        n_cmp++;
        if (lat !== WIDTH || bus.diff !== 8'h02 || bus.bout !== 1'b0) begin
            n_err++; $display("FAIL ignore_busy: lat=%0d diff=%h bout=%b need lat=%0d diff=02 bout=0",
                              lat, bus.diff, bus.bout, WIDTH);
        end
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones !== 1 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL ignore_busy_single_done: dones=%0d busy=%b need 1 and 0", dones, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(8'h05, 8'h03, 1'b0, lat);
        // still in the done cycle: request the next one immediately
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== WIDTH || bus.diff !== 8'h0F || bus.bout !== 1'b0) begin
            n_err++; $display("FAIL back_to_back: lat=%0d diff=%h bout=%b need lat=%0d diff=0f bout=0",
                              lat, bus.diff, bus.bout, WIDTH);
        end
    endtask

    task automatic test_mid_reset();
        int dones, lat;
        do_op(8'h80, 8'h01, 1'b0, lat);  // leave nonzero outputs behind
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11; bus.bin = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.diff, bus.bout, get_ovf()} !== '0) begin
            n_err++; $display("FAIL mid_reset: busy=%b done=%b diff=%h bout=%b ovf=%b, required all 0",
                              bus.busy, bus.done, bus.diff, bus.bout, get_ovf());
        end
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++; $display("FAIL mid_reset_no_done: activity cycles=%0d need 0", dones);
        end
        do_op(8'h10, 8'h01, 1'b0, lat);
        n_cmp++;
        if (lat !== WIDTH || bus.diff !== 8'h0F) begin
            n_err++; $display("FAIL mid_reset_restart: lat=%0d diff=%h need lat=%0d diff=0f", lat, bus.diff, WIDTH);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic             c;
        logic [WIDTH:0]   exp;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); c = 1'($urandom);
            if (i % 50 == 0) begin a = '0; b = '1; end
            exp = ref_sub(a, b, c);
            do_op(a, b, c, lat);
            n_cmp++;
            if (lat !== WIDTH || {bus.bout, bus.diff} !== exp) begin
                n_err++; $display("FAIL random%0d a=%h b=%h bin=%b: lat=%0d bout=%b diff=%h need lat=%0d bout=%b diff=%h",
                                  i, a, b, c, lat, bus.bout, bus.diff, WIDTH, exp[WIDTH], exp[WIDTH-1:0]);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_cmp++;
            if (bus.ovf !== ref_ovf(a, b, c)) begin
                n_err++; $display("FAIL random%0d ovf a=%h b=%h bin=%b: got %b need %b",
                                  i, a, b, c, bus.ovf, ref_ovf(a, b, c));
            end
`endif
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
